// File: rtl/windowed_error_counter_pkg.sv
// Shared helpers for the windowed bit-error counter: window FSM states, popcount width, saturating add.
// Latency: none (types and functions only).
// Backpressure: none.
package windowed_error_counter_pkg;

    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_COMPLETE = 1'b1
    } win_state_t;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed to hold a popcount of pattern_w bits (0..pattern_w inclusive).
    function automatic int pop_width(input int pattern_w);
        return clog2(pattern_w + 1);
    endfunction

    // a + b clamped at 2**w-1; operands are zero-extended to 32 bits, so w <= 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/windowed_error_counter_if.sv
// Frame/pattern inputs and counter/alarm outputs of the windowed bit-error counter.
// Latency: n/a (wiring only).
// Backpressure: none; frames are accepted every cycle frame_valid & enable is high.
interface windowed_error_counter_if #(
    parameter int PATTERN_W = 24,
    parameter int COUNT_W   = 16,
    parameter int FRAME_W   = 16
);
    logic                 enable;
    logic                 clear;
    logic                 frame_valid;
    logic [PATTERN_W-1:0] pattern_tx;
    logic [PATTERN_W-1:0] pattern_rx;
    logic [PATTERN_W-1:0] bit_mask;
    logic [COUNT_W-1:0]   threshold;
    logic [COUNT_W-1:0]   errors;
    logic                 error_flag;
    logic [FRAME_W-1:0]   frames;
    logic [COUNT_W-1:0]   window_errors;
    logic                 window_valid;
    logic                 ber_alarm;

    modport master (
        output enable, clear, frame_valid, pattern_tx, pattern_rx, bit_mask, threshold,
        input  errors, error_flag, frames, window_errors, window_valid, ber_alarm
    );

    modport slave (
        input  enable, clear, frame_valid, pattern_tx, pattern_rx, bit_mask, threshold,
        output errors, error_flag, frames, window_errors, window_valid, ber_alarm
    );
endinterface

// File: rtl/windowed_error_counter_masked_popcount.sv
// Counts mismatching bits between tx and rx patterns, restricted to bits whose mask bit is 1.
// Latency: combinational.
// Backpressure: none.
module windowed_error_counter_masked_popcount
    import windowed_error_counter_pkg::*;
#(
    parameter int PATTERN_W = 24,
    parameter int POP_W     = pop_width(PATTERN_W)
) (
    input  logic [PATTERN_W-1:0] tx,
    input  logic [PATTERN_W-1:0] rx,
    input  logic [PATTERN_W-1:0] mask,
    output logic [POP_W-1:0]     count
);

    logic [PATTERN_W-1:0] diff;

    assign diff = (tx ^ rx) & mask;

    // Ripple sum of the selected mismatch bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < PATTERN_W; i++) begin
            count = count + POP_W'(diff[i]);
        end
    end

endmodule

// File: rtl/windowed_error_counter.sv
// Masked bit-error counter: saturating running total plus per-window total compared against a threshold.
// Latency: frames visible 1 cycle after the strobe, errors/window results 2 cycles after.
// Backpressure: none; one frame per cycle, clear drops the in-flight frame and any frame strobed with it.
module windowed_error_counter
    import windowed_error_counter_pkg::*;
#(
    parameter int PATTERN_W     = 24,
    parameter int COUNT_W       = 16,
    parameter int FRAME_W       = 16,
    parameter int WINDOW_FRAMES = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    windowed_error_counter_if.slave  bus
);

    localparam int                 POP_W    = pop_width(PATTERN_W);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [FRAME_W-1:0] WIN_LAST = FRAME_W'(WINDOW_FRAMES - 1);

    logic [POP_W-1:0]   pop_c;
    logic [POP_W-1:0]   pop_q;
    logic               v1;
    logic [FRAME_W-1:0] frames_q;
    logic [COUNT_W-1:0] errors_q;
    logic               error_flag_q;
    logic [COUNT_W-1:0] window_acc;
    logic [FRAME_W-1:0] win_idx;
    logic [COUNT_W-1:0] window_errors_q;
    logic               ber_alarm_q;
    win_state_t         state;
    win_state_t         state_nxt;

    logic               accept;
    logic               win_last;
    logic [COUNT_W-1:0] errors_sum;
    logic [COUNT_W-1:0] window_sum;

    assign accept     = bus.frame_valid & bus.enable;
    assign win_last   = v1 && (win_idx == WIN_LAST);
    assign errors_sum = COUNT_W'(sat_add(32'(errors_q), 32'(pop_q), COUNT_W));
    assign window_sum = COUNT_W'(sat_add(32'(window_acc), 32'(pop_q), COUNT_W));

    windowed_error_counter_masked_popcount #(
        .PATTERN_W (PATTERN_W),
        .POP_W     (POP_W)
    ) u_popcount (
        .tx    (bus.pattern_tx),
        .rx    (bus.pattern_rx),
        .mask  (bus.bit_mask),
        .count (pop_c)
    );

    // Stage 1: register the masked popcount of an accepted frame and count it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            v1       <= 1'b0;
            pop_q    <= '0;
            frames_q <= '0;
        end else if (bus.clear) begin
            v1       <= 1'b0;
            frames_q <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                pop_q    <= pop_c;
                frames_q <= frames_q + FRAME_W'(1);
            end
        end
    end

    // Stage 2: saturating total, sticky full-scale flag and window accumulation/close-out.
    always_ff @(posedge clock) begin
        if (!reset || bus.clear) begin
            errors_q        <= '0;
            error_flag_q    <= 1'b0;
            window_acc      <= '0;
            win_idx         <= '0;
            window_errors_q <= '0;
            ber_alarm_q     <= 1'b0;
        end else if (v1) begin
            errors_q <= errors_sum;
            if (errors_sum == CNT_MAX) begin
                error_flag_q <= 1'b1;
            end
            if (win_last) begin
                window_errors_q <= window_sum;
                ber_alarm_q     <= (window_sum > bus.threshold);
                window_acc      <= '0;
                win_idx         <= '0;
            end else begin
                window_acc <= window_sum;
                win_idx    <= win_idx + FRAME_W'(1);
            end
        end
    end

    // Window FSM state register; clear or reset abandons any pending completion pulse.
    always_ff @(posedge clock) begin
        if (!reset || bus.clear) begin
            state <= ST_COUNTING;
        end else begin
            state <= state_nxt;
        end
    end

    // COMPLETE is entered for exactly the cycle after a window's last frame; back-to-back
    // completions (single-frame windows) keep it there.
    always_comb begin
        state_nxt = ST_COUNTING;
        case (state)
            ST_COUNTING: state_nxt = win_last ? ST_COMPLETE : ST_COUNTING;
            ST_COMPLETE: state_nxt = win_last ? ST_COMPLETE : ST_COUNTING;
            default:     state_nxt = ST_COUNTING;
        endcase
    end

    // Outputs: window_valid is decoded from the FSM, everything else is a register.
    always_comb begin
        bus.window_valid  = (state == ST_COMPLETE);
        bus.errors        = errors_q;
        bus.error_flag    = error_flag_q;
        bus.frames        = frames_q;
        bus.window_errors = window_errors_q;
        bus.ber_alarm     = ber_alarm_q;
    end

endmodule
